io_bus_arbiter: RTL
===================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of each requester payload and of out_data.
REQ-002 Parameter TIMEOUT, default 255: maximum HOLD cycles without out_ready before the beat is dropped; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 4 bits: requester i has a beat pending.
REQ-006 The block SHALL have port req_data, input, 4*DATA_W bits: payload of requester i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port req_ready, output, 4 bits: beat from requester i is taken on this edge.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a granted beat.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: granted payload.
REQ-010 The block SHALL have port out_src, output, 2 bits: index of the requester that owns out_data.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in HOLD.
REQ-013 The block SHALL have port timeout_pulse, output, 1 bit: one-cycle pulse when a beat is dropped.
REQ-014 The block SHALL have port err_cnt, output, 8 bits: saturating count of dropped beats.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and HOLD.
REQ-016 In IDLE with req_valid nonzero, sel SHALL be the first set req_valid bit searched from rr_ptr upward modulo 4.
REQ-017 In IDLE, req_ready SHALL be combinationally onehot(sel) when any req_valid is set, and 0 otherwise.
REQ-018 In IDLE, req_ready SHALL NOT be driven from registered state.
REQ-019 On an IDLE edge with a grant, out_data SHALL be loaded from req_data[sel] and out_src from sel, and the FSM SHALL go to HOLD; out_valid is 1 from the next cycle (1-cycle latency).
REQ-020 In HOLD, req_ready SHALL be 4'b0000, and out_valid, out_data and out_src SHALL stay stable.
REQ-021 In HOLD, on out_ready=1 the FSM SHALL go to IDLE, set rr_ptr to (out_src+1) mod 4, and deassert out_valid on the next cycle.
REQ-022 Peak throughput SHALL be one beat per two cycles.
REQ-023 An 8-bit wait counter SHALL clear on HOLD entry and increment on each HOLD cycle with out_ready=0.
REQ-024 rr_ptr wrap-around SHALL follow 3 -> 0.
REQ-025 A requester that drops req_valid while not granted SHALL lose nothing.
REQ-026 out_data SHALL hold its last value in IDLE.
REQ-027 out_src SHALL hold its last value in IDLE.

Reset
REQ-028 While rst_n=0, the block SHALL force FSM=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_src=0, busy=0, timeout_pulse=0, err_cnt=0 and the wait counter to 0 immediately, without waiting for clk.
REQ-029 While rst_n=0, req_ready SHALL be 0.
REQ-030 Reset during HOLD SHALL discard the held beat with no timeout_pulse and no err_cnt change.
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-032 With macro IO_ARB_TIMEOUT_EN defined, when the wait counter reaches TIMEOUT in HOLD with out_ready=0, the block SHALL go to IDLE, deassert out_valid, pulse timeout_pulse for 1 cycle, and advance rr_ptr as in REQ-021.
REQ-033 With IO_ARB_TIMEOUT_EN defined, each drop SHALL increment err_cnt, saturating at 255.
REQ-034 With IO_ARB_TIMEOUT_EN defined, if out_ready=1 on the timeout cycle, the accept SHALL win: normal release with no pulse and no count.
REQ-035 With IO_ARB_TIMEOUT_EN undefined, HOLD SHALL wait indefinitely for out_ready.
REQ-036 With IO_ARB_TIMEOUT_EN undefined, timeout_pulse SHALL be tied to 0, err_cnt tied to 0, and no wait counter SHALL be synthesized.

Verification
REQ-037 Reset then req_valid=4'b0001, data0=32'hA5A5_0001, out_ready=1 -> req_ready=0001 same cycle, out_valid=1 with out_data=32'hA5A5_0001 and out_src=0 next cycle, out_valid=0 the cycle after.
REQ-038 req_valid=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles.
REQ-039 rr_ptr=3 and req_valid=4'b0110 -> grant 1, then 2, covering wrap-around.
REQ-040 Grant to requester 2, out_ready=0 for 10 cycles then 1 -> out_data and out_src stable for all 11 cycles and req_ready=0 throughout HOLD.
REQ-041 With IO_ARB_TIMEOUT_EN and TIMEOUT=4, out_ready=0 -> timeout_pulse after 4 HOLD cycles and err_cnt=1; a repeat with out_ready=1 on cycle 4 gives a normal accept and err_cnt remains 1.
REQ-042 rst_n=0 asserted mid-HOLD -> out_valid=0 before the next clk edge; after release, req_valid=4'b1000 is granted with rr_ptr starting at 0.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: four-requester round-robin arbiter feeding a single
// registered output slot. A grant in IDLE loads the slot and moves to HOLD;
// HOLD waits for out_ready and then hands priority to the next requester.
// Optional drop-on-timeout logic is compiled in with `define IO_ARB_TIMEOUT_EN.
module io_bus_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_valid,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  timeout_pulse,
    output logic [7:0]            err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          out_src_q, out_src_d;
    logic [1:0]          sel;
    logic                any_req;
    logic                grant;
    logic                drop;

    assign any_req = |req_valid;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping 3 -> 0.
    // Scanning downward lets the closest candidate overwrite the farther ones.
    always_comb begin
        sel = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[rr_ptr_q + 2'(k)]) begin
                sel = rr_ptr_q + 2'(k);
            end
        end
    end

    // Next-state, grant handshake and output-slot load.
    // req_ready is purely combinational in IDLE and gated off while in reset.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        req_ready  = 4'b0000;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && rst_n) begin
                    req_ready  = 4'b0001 << sel;
                    grant      = 1'b1;
                    state_d    = HOLD;
                    out_data_d = req_data[sel*DATA_W +: DATA_W];
                    out_src_d  = sel;
                end
            end
            HOLD: begin
                // drop is already masked by out_ready, so an accept always wins.
                if (out_ready || drop) begin
                    state_d  = IDLE;
                    rr_ptr_d = out_src_q + 2'd1;
                end
            end
        endcase
    end

    // State, priority pointer and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            out_data_q <= '0;
            out_src_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef IO_ARB_TIMEOUT_EN
    logic [7:0] wait_q;
    logic [7:0] err_q;
    logic       pulse_q;

    // The beat is dropped on the edge where the wait count would reach TIMEOUT.
    assign drop = (state_q == HOLD) && !out_ready && (wait_q == 8'(TIMEOUT - 1));

    // Wait counter, one-cycle drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= 8'd0;
            err_q   <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            if (grant) begin
                wait_q <= 8'd0;
            end else if ((state_q == HOLD) && !out_ready) begin
                wait_q <= wait_q + 8'd1;
            end
            pulse_q <= drop;
            if (drop && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign timeout_pulse = pulse_q;
    assign err_cnt       = err_q;
`else
    // HOLD waits forever; no counter exists in this build.
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign drop           = 1'b0;
    assign timeout_pulse  = 1'b0;
    assign err_cnt        = 8'd0;
`endif

endmodule
